// File: rtl/vh_parity_pkg.sv
// Shared definitions for the 16-bit vertical/horizontal parity codec.
// Holds codeword geometry, the decoded-word payload and the syndrome
// function used by both the coder (parity generation) and the decoder.
package vh_parity_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned CODE_W = 24;
  localparam int unsigned SYN_W  = ROWS + COLS;

  // Decoded word as it leaves stage 2
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
    logic [SYN_W-1:0]  syn;
  } dec_word_t;

  // {col_syn, row_syn}: recomputed parities XOR received parities.
  // With the parity fields of code zeroed this returns the parity bits,
  // which is how the coder uses it.
  function automatic logic [SYN_W-1:0] vh_syndrome(input logic [CODE_W-1:0] code);
    logic [ROWS-1:0] row_syn;
    logic [COLS-1:0] col_syn;
    for (int i = 0; i < ROWS; i++) begin
      row_syn[i] = (^code[4*i +: 4]) ^ code[DATA_W + i];
    end
    for (int j = 0; j < COLS; j++) begin
      col_syn[j] = code[j] ^ code[j + 4] ^ code[j + 8] ^ code[j + 12]
                 ^ code[DATA_W + ROWS + j];
    end
    return {col_syn, row_syn};
  endfunction

endpackage

// File: rtl/vh_syndrome_classify.sv
// Combinational syndrome, correction and classification of one codeword.
// Ports:
//   code_i  24-bit received codeword
//   word_o  corrected data, corr/uncorr flags and syndrome (combinational)
module vh_syndrome_classify
  import vh_parity_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output dec_word_t         word_o
);

  logic [SYN_W-1:0]  syn;
  logic [ROWS-1:0]   row_syn;
  logic [COLS-1:0]   col_syn;
  logic              row_zero, col_zero, row_one, col_one;
  logic [DATA_W-1:0] flip_mask;

  assign syn      = vh_syndrome(code_i);
  assign row_syn  = syn[ROWS-1:0];
  assign col_syn  = syn[SYN_W-1:ROWS];
  assign row_zero = (row_syn == '0);
  assign col_zero = (col_syn == '0);
  assign row_one  = $onehot(row_syn);
  assign col_one  = $onehot(col_syn);

  // Intersection of the failing row and column; only used when both are one-hot
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        flip_mask[4*i + j] = row_syn[i] & col_syn[j];
      end
    end
  end

  // Clean / single error (data or parity bit) / uncorrectable
  always_comb begin
    word_o.data   = code_i[DATA_W-1:0];
    word_o.corr   = 1'b0;
    word_o.uncorr = 1'b0;
    word_o.syn    = syn;
    if (row_zero && col_zero) begin
      word_o.corr = 1'b0;
    end else if ((row_one || row_zero) && (col_one || col_zero)) begin
      // one-hot in only one dimension means a parity bit was hit: data untouched
      word_o.corr = 1'b1;
      if (row_one && col_one) begin
        word_o.data = code_i[DATA_W-1:0] ^ flip_mask;
      end
    end else begin
      word_o.uncorr = 1'b1;
    end
  end

endmodule

// File: rtl/vh_parity_decoder.sv
// Vertical/horizontal parity decoder: 2-stage valid/ready pipeline with
// single-error correction and saturating error counters.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_code  codeword input handshake
//   out_valid/out_ready        corrected word output handshake
//   out_data/out_corr/out_uncorr/out_syn  corrected word, flags, syndrome
//   clr_cnt                    synchronous clear of both counters
//   cnt_corr/cnt_uncorr        saturating counts of handshaked flagged words
module vh_parity_decoder
  import vh_parity_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [SYN_W-1:0]  out_syn,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic              out_valid_q, out_valid_d;
  dec_word_t         out_word_q, out_word_d;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

  dec_word_t         cls_word_c;
  logic              s2_free_c;
  logic              out_hs_c;

  vh_syndrome_classify u_classify (
    .code_i (s1_code_q),
    .word_o (cls_word_c)
  );

  // Stage 2 can take a word when empty or draining this cycle
  assign s2_free_c = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_free_c;
  assign out_hs_c  = out_valid_q && out_ready;

  // Next-state for pipeline registers and counters
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_code_d    = s1_code_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
      end
    end

    if (s2_free_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_word_d = cls_word_c;
      end
    end

    // Clear wins over a same-cycle increment
    if (clr_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_hs_c) begin
      if (out_word_q.corr && (cnt_corr_q != '1)) begin
        cnt_corr_d = cnt_corr_q + CNT_W'(1);
      end
      if (out_word_q.uncorr && (cnt_uncorr_q != '1)) begin
        cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_word_q.data;
  assign out_corr   = out_word_q.corr;
  assign out_uncorr = out_word_q.uncorr;
  assign out_syn    = out_word_q.syn;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule
